iir_biquad_cascade: RTL and testbench
=====================================

Name: iir_biquad_cascade

Overview:
Parametrised successor to the team's fixed 5th-order streaming IIR. It implements an NSEC-section Direct-Form-I biquad cascade with run-time-loadable coefficients and per-section bypass. A single time-multiplexed multiply-accumulate engine does the arithmetic. It streams input samples from sample memory by read address and writes filtered samples back by write address, using the same load/WEN/data_done/Finish memory protocol as the existing filter.

Parameters:
DATA_W, 16, signed sample width (DIn, Yn)
COEF_W, 20, signed coefficient width
FRAC, 16, coefficient fractional bits (1.0 = 2^FRAC)
NSEC, 4, number of biquad sections (1..8)
ACC_W, 48, signed accumulator width
ADDR_W, 20, sample address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run from address 0 (ignored while busy)
busy  out  1  high from accepted start until Finish
coef_we  in  1  coefficient write strobe; honoured only when busy=0
coef_addr  in  ceil(log2(5*NSEC))  coefficient index = sec*5+k; k: 0=b0 1=b1 2=b2 3=a1 4=a2
coef_wdata  in  COEF_W  signed coefficient value
sec_bypass  in  NSEC  bit s=1: section s passes input unchanged
load  out  1  high in FETCH; memory presents DIn for RAddr in the same cycle
RAddr  out  ADDR_W  read address
DIn  in  DATA_W  input sample (combinational from RAddr)
data_done  in  1  high when RAddr is past the last sample
WEN  out  1  one-cycle write strobe
WAddr  out  ADDR_W  write address
Yn  out  DATA_W  filtered sample, valid when WEN=1
Finish  out  1  run complete; held until next accepted start or rst

Behaviour:
- Reset: async. Clears RAddr, WAddr, Yn, WEN, load, busy and Finish to 0, all coefficient registers to 0, all history registers to 0. State goes to IDLE. Reset mid-run abandons the run with no further writes.
- FSM states: IDLE, FETCH, MAC, WRITE, DONE.
- IDLE: start=1 moves to FETCH. On that transition: RAddr=0, history cleared, Finish=0, busy=1.
- FETCH (1 cycle): load=1.
  - data_done=1 goes to DONE; no write occurs.
  - Otherwise DIn is registered as section-0 input x and the FSM goes to MAC with section=0, tap=0, acc=0.
- MAC (5 cycles per section, NSEC sections, always taken even when bypassed):
  - Taps in order: acc += b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2.
  - Product width is DATA_W+COEF_W signed, sign-extended to ACC_W.
  - On tap 4, section output y = sat_DATA_W((acc_final + 2^(FRAC-1)) >>> FRAC), i.e. round half up with arithmetic shift.
  - If sec_bypass[s]=1: y = x, and section history is left unchanged.
  - Otherwise history updates: x2<=x1, x1<=x, y2<=y1, y1<=y.
  - y becomes the next section's x. After section NSEC-1 the FSM goes to WRITE.
- WRITE (1 cycle): WEN=1, WAddr=RAddr, Yn=final y. Next cycle: RAddr<=RAddr+1 and the FSM returns to FETCH.
- Throughput: one sample per 5*NSEC+2 cycles (22 at default). The first WEN occurs in the 22nd cycle after the start-sampling edge.
- DONE: Finish=1, busy=0, the FSM goes to IDLE. Finish stays high in IDLE.
- Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The accumulator does not wrap for any in-range inputs at defaults.
- Coefficient writes while busy=1 are ignored. Writes with coef_addr >= 5*NSEC are ignored.
- RAddr at 2^ADDR_W-1 wraps to 0; run termination relies on data_done only.
- start while busy is ignored. start in the same cycle as coef_we: the write is applied and the run starts; the new coefficient is used from sample 0.
- Yn holds its last value outside WRITE. WEN and load are 0 outside WRITE and FETCH respectively.

Test Plan:
1. Gain test. Sections 1..3 bypassed, section 0 b0=32768 (0.5), others 0. Inputs 1000, -1000, 7. Expected Yn 500, -500, 4 (3.5 rounds up) at WAddr 0, 1, 2. First WEN 22 cycles after start.
2. Recursion test. Section 0 b0=65536, a1=-32768, others 0; other sections bypassed. Impulse 1000 then zeros. Expected Yn 1000, 500, 250, 125, 63.
3. Saturation test. Section 0 b0=262144 (4.0). Inputs 20000 and -20000. Expected Yn 32767 and -32768.
4. Termination test. Assert data_done when RAddr=3. Expected exactly 3 WEN pulses (WAddr 0, 1, 2), then Finish=1 and busy=0. A second start clears Finish and restarts at RAddr=0 with zeroed history.
5. Coefficient-lock test. coef_we issued while busy, with b0 changed. Expected outputs unchanged for the whole run; the same write after Finish takes effect on the next run.
6. Reset test. Assert rst during MAC of sample 2. Expected all outputs 0 immediately, no further WEN, coefficients read back as 0 (a subsequent run with no writes yields Yn=0).

Source files
------------

// File: rtl/iir_biquad_cascade.sv
// -----------------------------------------------------------------------------
// iir_biquad_cascade
//
// Streaming NSEC-section Direct-Form-I biquad cascade. A single
// multiply-accumulate engine is shared over all sections and taps: each sample
// takes one FETCH cycle, 5*NSEC MAC cycles and one WRITE cycle.
//
// Samples are read from an external memory by read address and written back by
// write address. The memory drives DIn combinationally from RAddr and raises
// data_done once RAddr is past the last sample. That ends the run.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start / busy        one-cycle run request (ignored while busy) / run active
//   coef_we/addr/wdata  coefficient load, index = sec*5+k
//                       (k: b0,b1,b2,a1,a2); honoured only while idle
//   sec_bypass          per-section bypass; a bypassed section outputs its input
//   load, RAddr         fetch strobe and read address
//   DIn, data_done      sample read from memory, end-of-data flag
//   WEN, WAddr, Yn      one-cycle write strobe, write address, filtered sample
//   Finish              run complete; held until the next accepted start
// -----------------------------------------------------------------------------
module iir_biquad_cascade #(
   parameter  int DATA_W = 16,
   parameter  int COEF_W = 20,
   parameter  int FRAC   = 16,
   parameter  int NSEC   = 4,
   parameter  int ACC_W  = 48,
   parameter  int ADDR_W = 20,
   localparam int CA_W   = $clog2(5 * NSEC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   input  logic                     coef_we,
   input  logic [CA_W-1:0]          coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   input  logic [NSEC-1:0]          sec_bypass,
   output logic                     load,
   output logic [ADDR_W-1:0]        RAddr,
   input  logic signed [DATA_W-1:0] DIn,
   input  logic                     data_done,
   output logic                     WEN,
   output logic [ADDR_W-1:0]        WAddr,
   output logic signed [DATA_W-1:0] Yn,
   output logic                     Finish
);

   localparam int NCOEF  = 5 * NSEC;
   localparam int SEC_W  = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int PROD_W = DATA_W + COEF_W;

   localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(64'sd1 <<< (DATA_W - 1)));

   typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;

   state_t                     state;
   logic signed [COEF_W-1:0]   coef [NCOEF];
   logic signed [DATA_W-1:0]   x1 [NSEC];
   logic signed [DATA_W-1:0]   x2 [NSEC];
   logic signed [DATA_W-1:0]   y1 [NSEC];
   logic signed [DATA_W-1:0]   y2 [NSEC];
   logic signed [DATA_W-1:0]   x_cur;     // input of the section being computed
   logic signed [ACC_W-1:0]    acc;
   logic [SEC_W-1:0]           sec;
   logic [2:0]                 tap;

   // Shared MAC datapath
   logic [CA_W-1:0]            cidx;
   logic signed [COEF_W-1:0]   coef_sel;
   logic signed [DATA_W-1:0]   samp_sel;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    rnd;
   logic signed [DATA_W-1:0]   y_sat;
   logic signed [DATA_W-1:0]   y_sec;

   // NOTE: always_comb gives every output a default first so that no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      cidx     = CA_W'(32'(sec) * 5 + 32'(tap));
      coef_sel = coef[cidx];
      samp_sel = x_cur;
      unique case (tap)
         3'd0:    samp_sel = x_cur;
         3'd1:    samp_sel = x1[sec];
         3'd2:    samp_sel = x2[sec];
         3'd3:    samp_sel = y1[sec];
         default: samp_sel = y2[sec];
      endcase
      prod     = samp_sel * coef_sel;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
      // Feedback taps carry -a1, -a2: subtract the product.
      acc_next = (tap >= 3'd3) ? acc - prod_ext : acc + prod_ext;
      // Round half up, then clamp to the sample range.
      rnd      = (acc_next + HALF) >>> FRAC;
      if (rnd > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
      else if (rnd < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
      else                  y_sat = rnd[DATA_W-1:0];
      y_sec    = sec_bypass[sec] ? x_cur : y_sat;
   end

   // Coefficient bank. It is reset to zero so that a filter never runs on
   // stale taps after rst. Writes are locked out while a run is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
      end else if (coef_we && !busy && (32'(coef_addr) < NCOEF)) begin
         coef[coef_addr] <= coef_wdata;
      end
   end

   // Control FSM, history and registered outputs.
   // NOTE: sequential state is assigned with <= only, so every register
   // samples the pre-edge values of its sources regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         Finish <= 1'b0;
         load   <= 1'b0;
         WEN    <= 1'b0;
         RAddr  <= '0;
         WAddr  <= '0;
         Yn     <= '0;
         x_cur  <= '0;
         acc    <= '0;
         sec    <= '0;
         tap    <= '0;
         for (int s = 0; s < NSEC; s++) begin
            x1[s] <= '0;
            x2[s] <= '0;
            y1[s] <= '0;
            y2[s] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= FETCH;
                  RAddr  <= '0;
                  Finish <= 1'b0;
                  busy   <= 1'b1;
                  load   <= 1'b1;
                  for (int s = 0; s < NSEC; s++) begin
                     x1[s] <= '0;
                     x2[s] <= '0;
                     y1[s] <= '0;
                     y2[s] <= '0;
                  end
               end
            end

            FETCH: begin
               load <= 1'b0;
               if (data_done) begin
                  state <= DONE;
               end else begin
                  x_cur <= DIn;
                  sec   <= '0;
                  tap   <= '0;
                  acc   <= '0;
                  state <= MAC;
               end
            end

            MAC: begin
               if (tap != 3'd4) begin
                  acc <= acc_next;
                  tap <= tap + 3'd1;
               end else begin
                  // A bypassed section still takes its 5 cycles so the sample
                  // period stays fixed; its history is frozen.
                  if (!sec_bypass[sec]) begin
                     x2[sec] <= x1[sec];
                     x1[sec] <= x_cur;
                     y2[sec] <= y1[sec];
                     y1[sec] <= y_sat;
                  end
                  x_cur <= y_sec;
                  acc   <= '0;
                  tap   <= '0;
                  if (sec == SEC_W'(NSEC - 1)) begin
                     state <= WRITE;
                     WEN   <= 1'b1;
                     WAddr <= RAddr;
                     Yn    <= y_sec;
                  end else begin
                     sec <= sec + SEC_W'(1);
                  end
               end
            end

            WRITE: begin
               WEN   <= 1'b0;
               RAddr <= RAddr + ADDR_W'(1);
               load  <= 1'b1;
               state <= FETCH;
            end

            DONE: begin
               Finish <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// -----------------------------------------------------------------------------
// tb_iir_biquad_cascade
//
// Directed bench for iir_biquad_cascade at default parameters. A behavioural
// model evaluates each biquad with its difference equation and supplies the
// expected Yn/WAddr for every write strobe. Hand-computed literals pin the
// model. The sample memory is combinational on RAddr.
// -----------------------------------------------------------------------------
module tb_iir_biquad_cascade;

   localparam int DATA_W = 16;
   localparam int COEF_W = 20;
   localparam int NSEC   = 4;
   localparam int ADDR_W = 20;
   localparam int CA_W   = 5;
   localparam int MEM_N  = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic                     busy;
   logic                     coef_we = 1'b0;
   logic [CA_W-1:0]          coef_addr = '0;
   logic signed [COEF_W-1:0] coef_wdata = '0;
   logic [NSEC-1:0]          sec_bypass = '0;
   logic                     load;
   logic [ADDR_W-1:0]        raddr;
   logic signed [DATA_W-1:0] din;
   logic                     data_done;
   logic                     wen;
   logic [ADDR_W-1:0]        waddr;
   logic signed [DATA_W-1:0] yn;
   logic                     finish;

   iir_biquad_cascade dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .sec_bypass (sec_bypass),
      .load       (load),
      .RAddr      (raddr),
      .DIn        (din),
      .data_done  (data_done),
      .WEN        (wen),
      .WAddr      (waddr),
      .Yn         (yn),
      .Finish     (finish)
   );

   always #5 clk = ~clk;

   // Sample memory
   logic signed [DATA_W-1:0] mem [MEM_N];
   int                       n_samp = 0;
   assign din       = (32'(raddr) < MEM_N) ? mem[raddr[3:0]] : '0;
   assign data_done = (32'(raddr) >= n_samp);

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int first_wen_cyc = -1;
   int wen_count = 0;
   int got_y [$];
   int exp_y [$];
   int exp_a [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_coef [5*NSEC];
   longint m_x1 [NSEC], m_x2 [NSEC], m_y1 [NSEC], m_y2 [NSEC];

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint model_step(input longint x_in);
      longint x, y, s_acc;
      x = x_in;
      for (int s = 0; s < NSEC; s++) begin
         if (sec_bypass[s]) continue;
         s_acc = m_coef[s*5+0]*x + m_coef[s*5+1]*m_x1[s] + m_coef[s*5+2]*m_x2[s]
               - m_coef[s*5+3]*m_y1[s] - m_coef[s*5+4]*m_y2[s];
         y = sat16((s_acc + 32768) >>> 16);
         m_x2[s] = m_x1[s]; m_x1[s] = x;
         m_y2[s] = m_y1[s]; m_y1[s] = y;
         x = y;
      end
      return x;
   endfunction

   // Compare process: every write strobe is checked against the model queue.
   always @(negedge clk) begin
      if (!rst && wen) begin
         wen_count++;
         if (first_wen_cyc < 0) first_wen_cyc = cyc;
         got_y.push_back(int'(yn));
         if (exp_y.size() == 0) begin
            check("unexpected_wen", 1, 0);
         end else begin
            check("yn", longint'(yn), longint'(exp_y.pop_front()));
            check("waddr", longint'(waddr), longint'(exp_a.pop_front()));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers are entered and left just after a rising edge.
   task automatic write_coef(input int addr, input int val, input bit applied);
      coef_we    = 1'b1;
      coef_addr  = CA_W'(addr);
      coef_wdata = COEF_W'(val);
      if (applied && addr < 5*NSEC) m_coef[addr] = val;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic load_samples(input int n, input int v0, input int v1,
                               input int v2, input int v3, input int v4);
      int v [5];
      v = '{v0, v1, v2, v3, v4};
      for (int i = 0; i < MEM_N; i++) mem[i] = '0;
      for (int i = 0; i < n && i < 5; i++) mem[i] = DATA_W'(v[i]);
      n_samp = n;
   endtask

   // Starts a run; any coef_we already raised by the caller is applied in the
   // same cycle as start.
   task automatic start_run();
      for (int s = 0; s < NSEC; s++) begin
         m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
      end
      exp_y.delete(); exp_a.delete(); got_y.delete();
      for (int i = 0; i < n_samp; i++) begin
         exp_y.push_back(int'(model_step(longint'(mem[i]))));
         exp_a.push_back(i);
      end
      first_wen_cyc = -1;
      start = 1'b1;
      @(posedge clk); #1;
      start_cyc = cyc;
      start     = 1'b0;
      coef_we   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < (n_samp + 2) * 22 + 40; i++) begin
         @(negedge clk);
         if (finish) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_finish"}, seen, 1);
      check({name, "_busy_low"}, busy, 0);
      check({name, "_all_written"}, exp_y.size(), 0);
      @(posedge clk); #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      for (int i = 0; i < MEM_N; i++) mem[i] = '0;
      for (int i = 0; i < 5*NSEC; i++) m_coef[i] = 0;

      #23;
      check("rst_raddr", raddr, 0);
      check("rst_waddr", waddr, 0);
      check("rst_yn", yn, 0);
      check("rst_wen", wen, 0);
      check("rst_load", load, 0);
      check("rst_busy", busy, 0);
      check("rst_finish", finish, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1. Gain: section 0 b0 = 0.5, sections 1..3 bypassed.
      sec_bypass = 4'b1110;
      write_coef(0, 32768, 1);
      write_coef(20, 65536, 0);     // out-of-range index, ignored
      load_samples(3, 1000, -1000, 7, 0, 0);
      start_run();
      check("t1_busy_after_start", busy, 1);
      wait_done("t1");
      check("t1_latency", first_wen_cyc - start_cyc, 21);  // 22nd cycle
      check("t1_y0_lit", got_y[0], 500);
      check("t1_y1_lit", got_y[1], -500);
      check("t1_y2_lit", got_y[2], 4);

      // 2. Recursion: b0 = 1.0, a1 = -0.5.
      write_coef(0, 65536, 1);
      write_coef(3, -32768, 1);
      load_samples(5, 1000, 0, 0, 0, 0);
      start_run();
      wait_done("t2");
      check("t2_y0_lit", got_y[0], 1000);
      check("t2_y1_lit", got_y[1], 500);
      check("t2_y2_lit", got_y[2], 250);
      check("t2_y3_lit", got_y[3], 125);
      check("t2_y4_lit", got_y[4], 63);

      // 3. Saturation: b0 = 4.0, no feedback.
      write_coef(0, 262144, 1);
      write_coef(3, 0, 1);
      load_samples(2, 20000, -20000, 0, 0, 0);
      start_run();
      wait_done("t3");
      check("t3_pos_sat_lit", got_y[0], 32767);
      check("t3_neg_sat_lit", got_y[1], -32768);

      // 4. Termination after 3 samples, then a restart with cleared history.
      write_coef(0, 65536, 1);
      write_coef(3, -32768, 1);
      load_samples(3, 1000, 0, 0, 0, 0);
      wen_count = 0;
      start_run();
      wait_done("t4a");
      check("t4_wen_count", wen_count, 3);
      check("t4_finish_held", finish, 1);
      start_run();
      check("t4_finish_cleared", finish, 0);
      check("t4_busy_set", busy, 1);
      check("t4_raddr_zero", raddr, 0);
      wait_done("t4b");
      check("t4_restart_y0_lit", got_y[0], 1000);
      check("t4_restart_y2_lit", got_y[2], 250);

      // 5. Coefficient lock while busy; the write then lands with start.
      load_samples(3, 1000, -1000, 7, 0, 0);
      start_run();
      write_coef(0, 32768, 0);       // busy: ignored
      wait_done("t5a");
      check("t5_locked_y0_lit", got_y[0], 1000);
      coef_we    = 1'b1;             // same cycle as start
      coef_addr  = 5'd0;
      coef_wdata = 20'sd32768;
      m_coef[0]  = 32768;
      write_coef(3, 0, 1);           // drop feedback before the next run
      coef_we    = 1'b1;
      coef_addr  = 5'd0;
      coef_wdata = 20'sd32768;
      start_run();
      wait_done("t5b");
      check("t5_new_y0_lit", got_y[0], 500);
      check("t5_new_y2_lit", got_y[2], 4);

      // 6. Reset during MAC of sample 2.
      load_samples(5, 1000, 2000, 3000, 4000, 5000);
      start_run();
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (raddr == 2 && !load && !wen) begin
               hit = 1'b1;
               break;
            end
         end
         check("t6_reached_mac", hit, 1);
      end
      #2 rst = 1'b1;
      #1;
      check("t6_raddr", raddr, 0);
      check("t6_yn", yn, 0);
      check("t6_busy", busy, 0);
      check("t6_load", load, 0);
      check("t6_wen", wen, 0);
      exp_y.delete(); exp_a.delete();
      wen_count = 0;
      for (int i = 0; i < 5*NSEC; i++) m_coef[i] = 0;
      repeat (30) @(posedge clk);
      check("t6_no_wen_in_reset", wen_count, 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      sec_bypass = '0;
      load_samples(3, 1000, -2000, 3000, 0, 0);
      start_run();
      wait_done("t6");
      check("t6_zero_coef_y0_lit", got_y[0], 0);
      check("t6_wen_after_reset", wen_count, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
